ex_operand_stage: RTL and testbench



---
 rtl/ex_operand_stage.sv | 120 ++++++++++++
 tb/tb_ex_operand_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX stage register with MEM/WB operand forwarding, load-use stall detection
// and branch flush, feeding the ALU operands and control.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [CTRL_WIDTH-1:0]     id_alu_control,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    output logic [DATA_WIDTH-1:0]     data1,
    output logic [DATA_WIDTH-1:0]     data2,
    output logic [CTRL_WIDTH-1:0]     ALUControl,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic                      stall
);

    logic                      vld_p1;
    logic                      reg_write_p1;
    logic                      mem_read_p1;
    logic                      alu_src_p1;
    logic [REG_ADDR_WIDTH-1:0] rs_p1;
    logic [REG_ADDR_WIDTH-1:0] rt_p1;
    logic [REG_ADDR_WIDTH-1:0] rd_p1;
    logic [DATA_WIDTH-1:0]     rs_data_p1;
    logic [DATA_WIDTH-1:0]     rt_data_p1;
    logic [DATA_WIDTH-1:0]     imm_p1;
    logic [CTRL_WIDTH-1:0]     alu_control_p1;
    logic                      bubble;
    logic [DATA_WIDTH-1:0]     rs_fwd;
    logic [DATA_WIDTH-1:0]     rt_fwd;

    // Register 0 is hard-wired, so a write aimed at it never counts as a producer.
    function automatic logic fwd_hit(input logic                      wr,
                                     input logic [REG_ADDR_WIDTH-1:0] dst,
                                     input logic [REG_ADDR_WIDTH-1:0] src);
        return wr && (dst != '0) && (dst == src);
    endfunction

    assign stall = vld_p1 && mem_read_p1 && (rd_p1 != '0) && id_valid &&
                   ((id_rs == rd_p1) || (!id_alu_src && (id_rt == rd_p1)));

    assign bubble = flush || stall;

    // ---- ID -> EX boundary (p1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1         <= 1'b0;
            reg_write_p1   <= 1'b0;
            mem_read_p1    <= 1'b0;
            alu_src_p1     <= 1'b0;
            rs_p1          <= '0;
            rt_p1          <= '0;
            rd_p1          <= '0;
            rs_data_p1     <= '0;
            rt_data_p1     <= '0;
            imm_p1         <= '0;
            alu_control_p1 <= '0;
        end else begin
            vld_p1         <= id_valid && !bubble;
            reg_write_p1   <= id_valid && !bubble && id_reg_write;
            mem_read_p1    <= id_valid && !bubble && id_mem_read;
            alu_src_p1     <= id_alu_src;
            rs_p1          <= id_rs;
            rt_p1          <= id_rt;
            rd_p1          <= id_rd;
            rs_data_p1     <= fwd_hit(wb_reg_write, wb_rd, id_rs) ? wb_result : id_rs_data;
            rt_data_p1     <= fwd_hit(wb_reg_write, wb_rd, id_rt) ? wb_result : id_rt_data;
            imm_p1         <= id_imm;
            alu_control_p1 <= id_alu_control;
        end
    end

    // ---- EX operand select (combinational from p1 plus MEM/WB) ----
    always_comb begin
        rs_fwd = rs_data_p1;
        if (fwd_hit(mem_reg_write, mem_rd, rs_p1)) begin
            rs_fwd = mem_result;
        end else if (fwd_hit(wb_reg_write, wb_rd, rs_p1)) begin
            rs_fwd = wb_result;
        end
        rt_fwd = rt_data_p1;
        if (fwd_hit(mem_reg_write, mem_rd, rt_p1)) begin
            rt_fwd = mem_result;
        end else if (fwd_hit(wb_reg_write, wb_rd, rt_p1)) begin
            rt_fwd = wb_result;
        end
    end

    assign data1        = rs_fwd;
    assign data2        = alu_src_p1 ? imm_p1 : rt_fwd;
    assign ex_rt_data   = rt_fwd;
    assign ALUControl   = alu_control_p1;
    assign ex_valid     = vld_p1;
    assign ex_reg_write = reg_write_p1;
    assign ex_mem_read  = mem_read_p1;
    assign ex_rd        = rd_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the EX slot.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_control;
    logic        id_reg_write, id_mem_read;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] data1, data2, ex_rt_data;
    logic [3:0]  ALUControl;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd;
    logic        stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .data1(data1), .data2(data2), .ALUControl(ALUControl),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_rt_data(ex_rt_data), .stall(stall)
    );

    // Model of the instruction sitting in EX.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        alu_src;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_val, rt_val, imm;
        logic [3:0]  ctrl;
    } slot_t;

    slot_t m;
    logic  known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Value of register r as EX should see it: the youngest in-flight writer wins.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] from_rf);
        logic        wr [2];
        logic [4:0]  dst [2];
        logic [31:0] val [2];
        wr[0] = mem_reg_write; dst[0] = mem_rd; val[0] = mem_result;
        wr[1] = wb_reg_write;  dst[1] = wb_rd;  val[1] = wb_result;
        if (r == 5'd0) return from_rf;
        for (int k = 0; k < 2; k++)
            if (wr[k] && dst[k] == r) return val[k];
        return from_rf;
    endfunction

    function automatic logic model_stall();
        logic uses_rd;
        uses_rd = (id_rs == m.rd) || (!id_alu_src && id_rt == m.rd);
        return m.valid && m.mem_read && (m.rd != 5'd0) && id_valid && uses_rd;
    endfunction

    task automatic compare_model();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.reg_write});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mem_read});
        chk("stall", {31'd0, stall}, {31'd0, model_stall()});
        if (known) begin
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            chk("ALUControl", {28'd0, ALUControl}, {28'd0, m.ctrl});
            chk("data1", data1, reg_value(m.rs, m.rs_val));
            chk("data2", data2, m.alu_src ? m.imm : reg_value(m.rt, m.rt_val));
            chk("ex_rt_data", ex_rt_data, reg_value(m.rt, m.rt_val));
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
    endtask

    task automatic advance();
        slot_t n;
        logic  squash;
        n = '0;
        if (reset) begin
            known = 1'b1;
        end else begin
            squash      = flush || model_stall();
            n.valid     = id_valid && !squash;
            n.reg_write = n.valid && id_reg_write;
            n.mem_read  = n.valid && id_mem_read;
            n.alu_src   = id_alu_src;
            n.rs        = id_rs;
            n.rt        = id_rt;
            n.rd        = id_rd;
            n.rs_val    = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs) ? wb_result : id_rs_data;
            n.rt_val    = (wb_reg_write && wb_rd != 0 && wb_rd == id_rt) ? wb_result : id_rt_data;
            n.imm       = id_imm;
            n.ctrl      = id_alu_control;
            known       = n.valid;
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alu_src = 0; id_alu_control = 0; id_reg_write = 0; id_mem_read = 0;
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic alu_src, input logic [31:0] imm,
                          input logic rw, input logic mr);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_alu_src = alu_src; id_imm = imm;
        id_alu_control = 4'd0; id_reg_write = rw; id_mem_read = mr;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        m = '0;
        known = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with a valid instruction in ID
        set_id(5'd1, 5'd2, 5'd3, 32'd11, 32'd12, 1'b0, 32'd0, 1'b1, 1'b1);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_valid", {31'd0, ex_valid}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_data1", data1, 32'd0);
            advance();
        end
        sample();
        chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_data2", data2, 32'd0);
        chk("rst_ctrl", {28'd0, ALUControl}, 32'd0);

        // First add after release
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd4, 1'b0, 32'd0, 1'b1, 1'b0);
        advance();
        id_valid = 0;
        sample();
        chk("add_data1", data1, 32'd5);
        chk("add_data2", data2, 32'd4);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        advance();

        // Forward priority
        clear_inputs();
        set_id(5'd3, 5'd4, 5'd5, 32'd11, 32'd12, 1'b0, 32'd0, 1'b1, 1'b0);
        advance();
        id_valid = 0;
        mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'd100;
        wb_reg_write = 1;  wb_rd = 5'd3;  wb_result = 32'd200;
        sample();
        chk("fwd_mem_wins", data1, 32'd100);
        mem_reg_write = 0;
        #1;
        compare_model();
        chk("fwd_wb", data1, 32'd200);
        advance();
        clear_inputs();
        set_id(5'd0, 5'd4, 5'd5, 32'd77, 32'd12, 1'b0, 32'd0, 1'b1, 1'b0);
        advance();
        id_valid = 0;
        mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'd100;
        wb_reg_write = 1;  wb_rd = 5'd0;  wb_result = 32'd200;
        sample();
        chk("fwd_r0", data1, 32'd77);
        advance();

        // Immediate select with MEM hit on rt
        clear_inputs();
        set_id(5'd1, 5'd5, 5'd6, 32'd3, 32'd9, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
        advance();
        id_valid = 0;
        mem_reg_write = 1; mem_rd = 5'd5; mem_result = 32'h1234;
        sample();
        chk("imm_data2", data2, 32'hFFFF_FFF0);
        chk("imm_rt_data", ex_rt_data, 32'h1234);
        advance();

        // Load-use on rs
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd7, 32'd0, 32'd0, 1'b1, 32'd8, 1'b1, 1'b1);
        advance();
        set_id(5'd7, 5'd2, 5'd8, 32'd0, 32'd6, 1'b0, 32'd0, 1'b1, 1'b0);
        sample();
        chk("lu_stall_t", {31'd0, stall}, 32'd1);
        advance();
        sample();
        chk("lu_stall_t1", {31'd0, stall}, 32'd0);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        advance();
        id_valid = 0;
        mem_reg_write = 0;
        wb_reg_write = 1; wb_rd = 5'd7; wb_result = 32'h55;
        sample();
        chk("lu_data1", data1, 32'h55);
        chk("lu_issue", {31'd0, ex_valid}, 32'd1);
        advance();

        // Load then rt dependence with immediate operand: no stall
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd7, 32'd0, 32'd0, 1'b1, 32'd8, 1'b1, 1'b1);
        advance();
        set_id(5'd1, 5'd7, 5'd8, 32'd0, 32'd0, 1'b1, 32'd4, 1'b1, 1'b0);
        sample();
        chk("lu_imm_nostall", {31'd0, stall}, 32'd0);
        advance();
        id_valid = 0;
        sample();
        chk("lu_imm_issue", {31'd0, ex_valid}, 32'd1);
        advance();

        // Flush of a valid reg_write instruction
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0);
        flush = 1;
        advance();
        clear_inputs();
        sample();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        advance();

        // Flush during a load-use stall
        set_id(5'd1, 5'd2, 5'd7, 32'd0, 32'd0, 1'b1, 32'd8, 1'b1, 1'b1);
        advance();
        set_id(5'd7, 5'd2, 5'd8, 32'd0, 32'd6, 1'b0, 32'd0, 1'b1, 1'b0);
        flush = 1;
        sample();
        chk("fl_stall_reported", {31'd0, stall}, 32'd1);
        advance();
        clear_inputs();
        sample();
        chk("fl_stall_bubble", {31'd0, ex_valid}, 32'd0);
        advance();
        sample();
        chk("fl_no_dup", {31'd0, ex_valid}, 32'd0);
        advance();

        // Capture bypass from WB into the stage register
        clear_inputs();
        set_id(5'd9, 5'd2, 5'd3, 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0);
        wb_reg_write = 1; wb_rd = 5'd9; wb_result = 32'd42;
        advance();
        id_valid = 0;
        wb_rd = 5'd3; wb_result = 32'd999;
        sample();
        chk("cap_bypass", data1, 32'd42);
        advance();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 99) < 3);
            flush          = ($urandom_range(0, 99) < 10);
            id_valid       = ($urandom_range(0, 99) < 80);
            id_rs          = 5'($urandom_range(0, 7));
            id_rt          = 5'($urandom_range(0, 7));
            id_rd          = 5'($urandom_range(0, 7));
            id_rs_data     = $urandom;
            id_rt_data     = $urandom;
            id_imm         = $urandom;
            id_alu_src     = 1'($urandom_range(0, 1));
            id_alu_control = 4'($urandom_range(0, 15));
            id_reg_write   = 1'($urandom_range(0, 1));
            id_mem_read    = ($urandom_range(0, 99) < 35);
            mem_reg_write  = 1'($urandom_range(0, 1));
            mem_rd         = 5'($urandom_range(0, 7));
            mem_result     = $urandom;
            wb_reg_write   = 1'($urandom_range(0, 1));
            wb_rd          = 5'($urandom_range(0, 7));
            wb_result      = $urandom;
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
